// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and
// stream framing constants.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_CKSUM  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus bundle: byte stream in, instruction-memory write port and boot status out.
interface imem_loader_if;

    // A byte moves on a rising edge where byte_valid && byte_ready; byte_data is
    // ignored otherwise, and the source must hold byte/valid until that edge.
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_reset, done, error
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_reset, done, error
    );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Big-endian word assembler: shifts accepted bytes in MSB first and flags the 4th byte.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (shift_i) begin
            word_d = {word_q[23:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
    assign full_o = shift_i && (cnt_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> consecutive instruction-memory words,
// holding the CPU in reset until done. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          WORDS     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset,
    imem_loader_if.master bus,
    output logic [2:0]    dbg_state_o
);

    localparam int               IDX_W   = $clog2(WORDS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0]       S_FINISH = S_CKSUM;
`else
    localparam logic [2:0]       S_FINISH = S_DONE;
`endif

    state_t           state_q, state_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_next;
    logic [LEN_W-1:0] new_len;
    logic             accept;
    logic             shift;
    logic             full;
    logic [31:0]      word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       ck_q, ck_d;
`endif

    // Outputs decode only from registered state so byte_valid never reaches them.
    assign bus.byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                            (state_q == S_DATA)   || (state_q == S_CKSUM);
    assign bus.wr_en      = (state_q == S_WRITE);
    assign bus.wr_addr    = BASE_ADDR + (32'(idx_q) << 2);
    assign bus.wr_data    = word;
    assign bus.cpu_reset  = (state_q != S_DONE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.error      = (state_q == S_ERROR);
    assign dbg_state_o    = state_q;

    assign accept   = bus.byte_valid && bus.byte_ready;
    assign shift    = accept && (state_q == S_DATA);
    assign new_len  = {len_hi_q, bus.byte_data};
    assign idx_next = idx_q + IDX_W'(1);

    word_assembler u_word_assembler (
        .clock   (clock),
        .reset   (reset),
        .shift_i (shift),
        .byte_i  (bus.byte_data),
        .word_o  (word),
        .full_o  (full)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        idx_d    = idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ck_d     = ck_q;
`endif
        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = bus.byte_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = new_len;
                    if (new_len > MAX_LEN)  state_d = S_ERROR;
                    else if (new_len == '0) state_d = S_FINISH;
                    else                    state_d = S_DATA;
                end
            end
            S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (shift) ck_d = ck_q ^ bus.byte_data;
`endif
                if (full) state_d = S_WRITE;
            end
            S_WRITE: begin
                idx_d = idx_next;
                if (LEN_W'(idx_next) == len_q) state_d = S_FINISH;
                else                           state_d = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CKSUM: begin
                if (accept) state_d = (bus.byte_data == ck_q) ? S_DONE : S_ERROR;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_LEN_HI;
            len_hi_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ck_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ck_q     <= ck_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load streams plus a mid-load reset sequence.
module tb_imem_loader;

    localparam int          WORDS = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        logic [15:0] n;
        logic        toggle;
        logic        fixed;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        bad_ck;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [2:0]  dbg_state;
    imem_loader_if bus();

    logic [63:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    int          wr_cnt;
    int          rdy_low;
    vec_t        vecs[9];
    int          nvec;
    logic [7:0]  ck;

    imem_loader #(.WORDS(WORDS), .BASE_ADDR(BASE)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.master),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.wr_en) begin
                logic [63:0] e;
                wr_cnt++;
                check("ready_in_write", 64'(bus.byte_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: actual addr=%0h data=%0h required=no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.wr_addr), 64'(e[63:32]));
                    check("wr_data", 64'(bus.wr_data), 64'(e[31:0]));
                end
            end
            if (!bus.byte_ready && !bus.done && !bus.error) rdy_low++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  64'(bus.byte_ready), 64'd1);
        check({tag, "_wr_en"},  64'(bus.wr_en),      64'd0);
        check({tag, "_addr"},   64'(bus.wr_addr),    64'(BASE));
        check({tag, "_data"},   64'(bus.wr_data),    64'd0);
        check({tag, "_cpurst"}, 64'(bus.cpu_reset),  64'd1);
        check({tag, "_done"},   64'(bus.done),       64'd0);
        check({tag, "_error"},  64'(bus.error),      64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.byte_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check_reset_vals("rst");
        reset = 1'b0;
        wr_cnt = 0;
        rdy_low = 0;
        ck = 8'h00;
    endtask

    // Called at posedge+1; returns at posedge+1 of the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b, input logic gap);
        int t;
        if (gap) begin
            bus.byte_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        t = 0;
        while (!bus.byte_ready && t < 8) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (!bus.byte_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: actual ready=0 required ready=1 for byte %0h", b);
        end else begin
            @(posedge clock);
            #1;
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input logic gap);
        exp_q.push_back({BASE + 32'(idx) * 32'd4, w});
        for (int k = 3; k >= 0; k--) begin
            ck = ck ^ w[8*k +: 8];
            send_byte(w[8*k +: 8], gap);
        end
    endtask

    task automatic wait_end(output int lat);
        lat = 0;
        while (!(bus.done || bus.error) && lat < 10) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        logic        ovf;
        logic [31:0] w;
        int          lat;
        int          lat_exp;
        int          nw;
        string       tag;
        tag = $sformatf("v%0d", vi);
        do_reset();
        ovf = (v.n > 16'(WORDS));
        send_byte(v.n[15:8], v.toggle);
        send_byte(v.n[7:0], v.toggle);
        nw = ovf ? 0 : int'(v.n);
        for (int j = 0; j < nw; j++) begin
            if (v.fixed) w = (j == 0) ? v.w0 : v.w1;
            else         w = $urandom;
            send_word(w, j, v.toggle);
        end
        lat_exp = (ovf || v.n == 16'd0) ? 0 : 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!ovf) begin
            send_byte(v.bad_ck ? (ck ^ 8'h01) : ck, v.toggle);
            lat_exp = 0;
        end
`endif
        wait_end(lat);
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check({tag, "_done"},    64'(bus.done),      64'(v.exp_done));
        check({tag, "_error"},   64'(bus.error),     64'(v.exp_err));
        check({tag, "_cpurst"},  64'(bus.cpu_reset), 64'(!v.exp_done));
        check({tag, "_ready"},   64'(bus.byte_ready), 64'd0);
        // Offer a byte in the terminal state: it must not be taken or cause a write.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        bus.byte_valid = 1'b0;
        check({tag, "_writes"},   64'(wr_cnt),       64'(nw));
        check({tag, "_rdy_low"},  64'(rdy_low),      64'(nw));
        check({tag, "_q_empty"},  64'(exp_q.size()), 64'd0);
        check({tag, "_hold"},     64'({bus.done, bus.error}), 64'({v.exp_done, v.exp_err}));
        exp_q.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        int lat;
        n_cmp = 0;
        n_err = 0;
        wr_cnt = 0;
        rdy_low = 0;
        ck = 8'h00;
        reset = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        //             n        tog   fix   w0            w1            badck done  err
        vecs[0] = '{16'd2,   1'b0, 1'b1, 32'h2008_0005, 32'hAC09_0000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'd0,   1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'd65,  1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'd1,   1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'd3,   1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'd64,  1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'd256, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1};
        nvec = 7;
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[7] = '{16'd1,   1'b0, 1'b1, 32'h1234_5678, 32'h0,         1'b0, 1'b1, 1'b0};
        vecs[8] = '{16'd1,   1'b1, 1'b1, 32'h1234_5678, 32'h0,         1'b1, 1'b0, 1'b1};
        nvec = 9;
`endif

        for (int i = 0; i < nvec; i++) run_vec(i, vecs[i]);

        // Reset after three data bytes of the first word, then a fresh one-word load.
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_vals("midrst");
        check("midrst_writes", 64'(wr_cnt), 64'd0);
        reset = 1'b0;
        ck = 8'h00;
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(32'hCAFE_F00D, 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(ck, 1'b0);
`endif
        wait_end(lat);
        check("fresh_done",    64'(bus.done),      64'd1);
        check("fresh_cpurst",  64'(bus.cpu_reset), 64'd0);
        check("fresh_writes",  64'(wr_cnt),        64'd1);
        check("fresh_q_empty", 64'(exp_q.size()),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
